// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit: one access at a time over a req/ack memory port.
// Stores are lane-shifted with byte strobes; loads are aligned and sign/zero-extended.
module load_store_unit #(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [REG_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0] req_wdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0] mem_wdata,
    output logic [7:0]           mem_wstrb,
    input  logic                 mem_ack,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic                 resp_valid,
    output logic [REG_WIDTH-1:0] resp_data,
    output logic                 resp_err
);
    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [2:0]             offset_q, offset_d;
    logic                   mem_we_q, mem_we_d;
    logic [REG_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [REG_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]             mem_wstrb_q, mem_wstrb_d;
    logic [REG_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;

    logic [2:0]             align_mask;
    logic [7:0]             byte_mask;
    logic                   legal;
    logic [REG_WIDTH-1:0]   raw;
    logic [REG_WIDTH-1:0]   load_ext;

    always_comb begin
        case (req_funct3[1:0])
            2'd0:    begin align_mask = 3'b000; byte_mask = 8'h01; end
            2'd1:    begin align_mask = 3'b001; byte_mask = 8'h03; end
            2'd2:    begin align_mask = 3'b011; byte_mask = 8'h0F; end
            default: begin align_mask = 3'b111; byte_mask = 8'hFF; end
        endcase
        legal = (req_funct3 != 3'b111) && !(req_we && req_funct3[2])
              && ((req_addr[2:0] & align_mask) == 3'b000);
    end

    // Load data is shifted down by the captured byte offset, then extended by size.
    always_comb begin
        raw = mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(REG_WIDTH-8){raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{(REG_WIDTH-16){raw[15]}}, raw[15:0]};
            3'b010:  load_ext = {{(REG_WIDTH-32){raw[31]}}, raw[31:0]};
            3'b100:  load_ext = {{(REG_WIDTH-8){1'b0}}, raw[7:0]};
            3'b101:  load_ext = {{(REG_WIDTH-16){1'b0}}, raw[15:0]};
            3'b110:  load_ext = {{(REG_WIDTH-32){1'b0}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    offset_d    = req_addr[2:0];
                    mem_we_d    = req_we;
                    mem_addr_d  = {req_addr[REG_WIDTH-1:3], 3'b000};
                    mem_wdata_d = req_we ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
                    mem_wstrb_d = req_we ? (byte_mask << req_addr[2:0]) : 8'h00;
                    if (legal) begin
                        state_d = S_MEM;
                    end else begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b0;
                    resp_data_d = we_q ? '0 : load_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 3'b000;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 8'h00;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_req    = (state_q == S_MEM);
    assign resp_valid = (state_q == S_RESP);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a byte-level model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic        resp_valid, resp_err;
    logic [63:0] resp_data;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.REG_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [63:0] a);
        if (f3 == 3'b111) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (a % 64'(size_of(f3))) == 64'd0;
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input int off);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < size_of(f3); i++) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] w, input int off);
        logic [63:0] d = 64'd0;
        for (int i = 0; off + i < 8; i++) d[8*(off+i) +: 8] = w[8*i +: 8];
        return d;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
        logic [63:0] res = 64'd0;
        int sz = size_of(f3);
        for (int i = 0; i < sz; i++) res = res | (64'(rd[8*(off+i) +: 8]) << (8*i));
        if (!f3[2] && sz < 8 && res[8*sz-1]) res = res | ~((64'd1 << (8*sz)) - 64'd1);
        return res;
    endfunction

    // Drives one access from IDLE, waits `waits` cycles before acking, and checks every cycle.
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] rd, input int waits,
                             input logic [63:0] exp_load, input logic use_exp);
        int off = int'(addr[2:0]);
        logic legal = model_legal(we, f3, addr);
        logic [63:0] exp_data = use_exp ? exp_load : model_load(f3, off, rd);
        chk({tag, ".ready_pre"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        if (!legal) begin
            chk({tag, ".err_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, ".err_flag"}, 64'(resp_err), 64'd1);
            chk({tag, ".err_data"}, resp_data, 64'd0);
            chk({tag, ".err_nomem"}, 64'(mem_req), 64'd0);
            step();
            chk({tag, ".err_nomem2"}, 64'(mem_req), 64'd0);
            chk({tag, ".err_ready"}, 64'(req_ready), 64'd1);
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            chk({tag, ".mem_req"}, 64'(mem_req), 64'd1);
            chk({tag, ".mem_addr"}, mem_addr, {addr[63:3], 3'b000});
            chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
            chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), we ? 64'(model_wstrb(f3, off)) : 64'd0);
            if (we) chk({tag, ".mem_wdata"}, mem_wdata, model_wdata(wd, off));
            chk({tag, ".no_resp"}, 64'(resp_valid), 64'd0);
            if (w < waits) begin
                mem_ack = 1'b0;
                req_valid = $urandom_range(0, 1);
                req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
                req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
            end else begin
                req_valid = 1'b0;
                mem_ack = 1'b1; mem_rdata = rd;
            end
            step();
        end
        mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, ".resp_err"}, 64'(resp_err), 64'd0);
        chk({tag, ".resp_data"}, resp_data, we ? 64'd0 : exp_data);
        chk({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
        step();
        chk({tag, ".resp_once"}, 64'(resp_valid), 64'd0);
        chk({tag, ".ready_post"}, 64'(req_ready), 64'd1);
    endtask

    localparam logic [63:0] RD = 64'h8877_6655_4433_22F1;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 64'd0; req_wdata = 64'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
        step(); step();
        rst = 1'b0;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.mem_we", 64'(mem_we), 64'd0);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.resp_err", 64'(resp_err), 64'd0);
        chk("rst.mem_addr", mem_addr, 64'd0);
        chk("rst.mem_wdata", mem_wdata, 64'd0);
        chk("rst.resp_data", resp_data, 64'd0);
        chk("rst.mem_wstrb", 64'(mem_wstrb), 64'd0);
        step();
        chk("idle.mem_req", 64'(mem_req), 64'd0);
        chk("idle.req_ready", 64'(req_ready), 64'd1);

        // Reset wins over a simultaneous request.
        rst = 1'b1; req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 64'h1000;
        step();
        rst = 1'b0; req_valid = 1'b0;
        chk("rstreq.mem_req", 64'(mem_req), 64'd0);
        chk("rstreq.ready", 64'(req_ready), 64'd1);

        do_access("lb",  1'b0, 3'b000, 64'h1000, 64'd0, RD, 0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        do_access("lbu", 1'b0, 3'b100, 64'h1000, 64'd0, RD, 0, 64'h0000_0000_0000_00F1, 1'b1);
        do_access("lh",  1'b0, 3'b001, 64'h1006, 64'd0, RD, 0, 64'hFFFF_FFFF_FFFF_8877, 1'b1);
        do_access("lwu", 1'b0, 3'b110, 64'h1004, 64'd0, RD, 0, 64'h0000_0000_8877_6655, 1'b1);
        do_access("ld",  1'b0, 3'b011, 64'h1000, 64'd0, RD, 0, 64'h8877_6655_4433_22F1, 1'b1);
        do_access("sh",  1'b1, 3'b001, 64'h2006, 64'hABCD, RD, 0, 64'd0, 1'b1);
        do_access("sw_wait", 1'b1, 3'b010, 64'h3004, 64'h1122_3344_5566_7788, RD, 4, 64'd0, 1'b1);
        do_access("lw_mis", 1'b0, 3'b010, 64'h1002, 64'd0, RD, 0, 64'd0, 1'b0);
        do_access("f3_111", 1'b0, 3'b111, 64'h1000, 64'd0, RD, 0, 64'd0, 1'b0);
        do_access("sbu_ill", 1'b1, 3'b100, 64'h1000, 64'd0, RD, 0, 64'd0, 1'b0);

        // Reset in MEM, then a late ack that must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h4000;
        step();
        req_valid = 1'b0;
        chk("midrst.in_mem", 64'(mem_req), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.mem_req", 64'(mem_req), 64'd0);
        chk("midrst.ready", 64'(req_ready), 64'd1);
        chk("midrst.no_resp", 64'(resp_valid), 64'd0);
        mem_ack = 1'b1; mem_rdata = RD;
        step();
        mem_ack = 1'b0;
        chk("lateack.no_resp", 64'(resp_valid), 64'd0);
        chk("lateack.ready", 64'(req_ready), 64'd1);
        chk("lateack.mem_req", 64'(mem_req), 64'd0);
        do_access("ld_after", 1'b0, 3'b011, 64'h5008, 64'd0, 64'h0123_4567_89AB_CDEF, 1,
                  64'h0123_4567_89AB_CDEF, 1'b1);

        for (int n = 0; n < 60; n++) begin
            do_access("rand", 1'($urandom_range(0, 1)), 3'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      int'($urandom_range(0, 3)), 64'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the 64-bit RISC-V core. It consumes the ALU result as the effective address, and rs2 as store data. It runs one access at a time over a simple request/acknowledge memory port. Load data is aligned and sign/zero-extended before being returned for register write-back. Misaligned accesses and illegal size encodings are flagged without touching memory.

## Interface
- `REG_WIDTH`, 64, register and data-bus width; only 64 is supported (8 byte lanes).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: access request from the core.
- `req_ready` out 1: high only in IDLE; an access is accepted on a cycle with `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3; loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000–011.
- `req_addr` in REG_WIDTH: effective byte address (ALU output).
- `req_wdata` in REG_WIDTH: store data (rs2), least-significant bytes used.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: memory write enable.
- `mem_addr` out REG_WIDTH: doubleword address, `{req_addr[63:3], 3'b000}`.
- `mem_wdata` out REG_WIDTH: lane-shifted store data.
- `mem_wstrb` out 8: byte-lane write strobes; all zero for loads.
- `mem_ack` in 1: memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in REG_WIDTH: read doubleword.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out REG_WIDTH: extended load result; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; set on a misaligned access or an illegal funct3.

## Operation
- The FSM has three states: IDLE, MEM, RESP.
- **IDLE:** `req_ready` = 1.
  - On accept, register `we`, `funct3`, `offset = req_addr[2:0]` and the memory-port outputs.
  - If the access is legal, go to MEM. If it is illegal, go to RESP with `resp_err` = 1.
- **Legality:** size = 1 << funct3[1:0] bytes. The address must be size-aligned (`addr mod size == 0`).
  - funct3 = 111 is illegal.
  - For stores, funct3[2] = 1 is illegal.
- **MEM:** `mem_req` = 1. All `mem_*` outputs are held constant until the cycle in which `mem_ack` = 1.
  - On ack, capture the load result and go to RESP.
- **RESP:** `resp_valid` = 1 for exactly one cycle, then go to IDLE.
- **Store lanes:**
  - `mem_wdata` = `req_wdata << (8*offset)`, truncated to 64 bits.
  - `mem_wstrb` = `((1<<size)-1) << offset`, e.g. SH at offset 6 gives 8'b1100_0000.
- **Load extraction:**
  - Take `raw = mem_rdata >> (8*offset)`.
  - Keep the low `size` bytes.
  - Sign-extend from the top kept bit when funct3[2] = 0; zero-extend otherwise. LD passes `raw` unchanged.
- **Reset:** forces IDLE.
  - Outputs after reset: `req_ready` = 1; `mem_req`, `mem_we`, `resp_valid`, `resp_err` = 0; `mem_addr`, `mem_wdata`, `resp_data` = 0; `mem_wstrb` = 0.
- **Ignored inputs:**
  - `mem_ack` outside MEM, including a late ack after a reset mid-access.
  - `req_valid` outside IDLE, without side effects.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `mem_ack` or `req_*` to any output.
- **Legal access:** accepted at edge T.
  - `mem_req` is high from cycle T+1.
  - Ack sampled at edge T+k (k ≥ 1).
  - `resp_valid` in cycle T+k+1.
  - `req_ready` is high again in cycle T+k+2.
- **Zero-wait memory** (ack in the first MEM cycle): `resp_valid` two cycles after accept, so back-to-back accepts are at most every 3 cycles.
- **Error path:** `resp_valid` and `resp_err` in the cycle after accept; `mem_req` never asserts.
- **Reset mid-access:** `rst` high at an edge while in MEM.
  - `mem_req` = 0 in the next cycle.
  - No `resp_valid` is produced for that access.
  - `req_ready` = 1 in the next cycle.
- Reset asserted in the same cycle as `req_valid`: reset wins, and the request is not accepted.
- `resp_data` and `resp_err` hold their value until the next response. They are meaningful only while `resp_valid` = 1.

## Test plan
- **Reset:** drive `rst` for 2 cycles, then release → all outputs at their reset values, `req_ready` = 1, and `mem_req` stays 0 with `req_valid` = 0.
- **Loads:** `mem_rdata` = 0x8877_6655_4433_22F1, zero-wait ack.
  - LB @0x1000 → `resp_data` 0xFFFF_FFFF_FFFF_FFF1; LBU @0x1000 → 0xF1.
  - LH @0x1006 → 0xFFFF_FFFF_FFFF_8877; LWU @0x1004 → 0x8877_6655.
  - LD @0x1000 → 0x8877_6655_4433_22F1.
  - For each load, `mem_addr` = 0x1000 and `resp_valid` two cycles after accept.
- **Store lanes:** SH, `req_wdata` 0xABCD, @0x2006 → `mem_wdata` 0xABCD_0000_0000_0000, `mem_wstrb` 8'hC0, `mem_addr` 0x2000, `mem_we` = 1; `resp_data` = 0 and `resp_err` = 0.
- **Wait states and errors:**
  - Hold `mem_ack` low for 4 cycles on an SW to 0x3004 → `mem_*` stable throughout, `req_valid` pulses ignored, `resp_valid` exactly once, in the cycle after ack.
  - LW @0x1002 and funct3 = 111 → `resp_err` = 1 one cycle after accept, `mem_req` never asserts.
- **Reset mid-access:** assert `rst` during MEM, then send a late `mem_ack` → no response, unit returns to IDLE, and a following LD completes normally.
